// File: rtl/aurora_hls_monitor_reporter.sv
// Periodic / on-demand telemetry reporter for the Aurora link monitor counters.
// Emits 4-beat AXI-Stream records of counter deltas; back-pressured reports are counted as drops.
module aurora_hls_monitor_reporter #(
    parameter int unsigned PERIOD_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_report,
    input  logic [31:0] core_status_not_ok_count,
    input  logic [31:0] fifo_rx_overflow_count,
    input  logic [31:0] fifo_tx_overflow_count,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] dropped_reports
);

    typedef enum logic [2:0] {IDLE, HDR, D0, D1, D2} state_t;

    localparam logic [31:0] PC_LAST = 32'(PERIOD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] prev_core_q, prev_core_d;
    logic [31:0] prev_rx_q, prev_rx_d;
    logic [31:0] prev_tx_q, prev_tx_d;
    logic [31:0] core_delta_q, core_delta_d;
    logic [31:0] rx_delta_q, rx_delta_d;
    logic [31:0] tx_delta_q, tx_delta_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [31:0] dropped_q, dropped_d;
    logic [15:0] seq_q, seq_d;
    logic        drop_flag_q, drop_flag_d;
    logic        tick, accept, drop;

    always_comb begin
        tick   = force_report || (enable && (pc_q == PC_LAST));
        accept = tvalid_q && m_axis_tready;
        drop   = tick && (state_q != IDLE);

        pc_d = (force_report || !enable || (pc_q == PC_LAST)) ? 32'd0 : pc_q + 32'd1;

        state_d      = state_q;
        prev_core_d  = prev_core_q;
        prev_rx_d    = prev_rx_q;
        prev_tx_d    = prev_tx_q;
        core_delta_d = core_delta_q;
        rx_delta_d   = rx_delta_q;
        tx_delta_d   = tx_delta_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        dropped_d    = dropped_q;
        seq_d        = seq_q;
        drop_flag_d  = drop_flag_q;

        // Output beats are loaded one edge ahead so tdata/tlast come straight from flops.
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d      = HDR;
                    core_delta_d = core_status_not_ok_count - prev_core_q;
                    rx_delta_d   = fifo_rx_overflow_count - prev_rx_q;
                    tx_delta_d   = fifo_tx_overflow_count - prev_tx_q;
                    prev_core_d  = core_status_not_ok_count;
                    prev_rx_d    = fifo_rx_overflow_count;
                    prev_tx_d    = fifo_tx_overflow_count;
                    tdata_d      = {8'hA5, 7'd0, drop_flag_q, seq_q};
                    tvalid_d     = 1'b1;
                    tlast_d      = 1'b0;
                end
            end
            HDR: begin
                if (accept) begin
                    state_d     = D0;
                    tdata_d     = core_delta_q;
                    drop_flag_d = 1'b0;
                end
            end
            D0: begin
                if (accept) begin
                    state_d = D1;
                    tdata_d = rx_delta_q;
                end
            end
            D1: begin
                if (accept) begin
                    state_d = D2;
                    tdata_d = tx_delta_q;
                    tlast_d = 1'b1;
                end
            end
            D2: begin
                if (accept) begin
                    state_d  = IDLE;
                    tdata_d  = 32'd0;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    seq_d    = seq_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A drop keeps prev untouched so the next record's deltas absorb the lost interval.
        if (drop) begin
            drop_flag_d = 1'b1;
            if (dropped_q != 32'hFFFF_FFFF) begin
                dropped_d = dropped_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            prev_core_q  <= '0;
            prev_rx_q    <= '0;
            prev_tx_q    <= '0;
            core_delta_q <= '0;
            rx_delta_q   <= '0;
            tx_delta_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            dropped_q    <= '0;
            seq_q        <= '0;
            drop_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prev_core_q  <= prev_core_d;
            prev_rx_q    <= prev_rx_d;
            prev_tx_q    <= prev_tx_d;
            core_delta_q <= core_delta_d;
            rx_delta_q   <= rx_delta_d;
            tx_delta_q   <= tx_delta_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            dropped_q    <= dropped_d;
            seq_q        <= seq_d;
            drop_flag_q  <= drop_flag_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign dropped_reports = dropped_q;

endmodule
